// File: rtl/reg_dia_cnt.sv
// Day-of-week register/counter for the RTC datapath: advances on rollover ticks,
// accepts user up/down steps and range-checked direct loads, drives a gated day code.
module reg_dia_cnt #(
    parameter int unsigned NUM_DAYS   = 7,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIRST_CODE = 1,
    parameter int unsigned RESET_IDX  = 0,
    localparam int unsigned IDX_W     = $clog2(NUM_DAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             EN,
    input  logic             inc,
    input  logic             dec,
    input  logic             ld,
    input  logic [IDX_W-1:0] ld_val,
    output logic [IDX_W-1:0] dia_idx,
    output logic [OUT_W-1:0] dia_code,
    output logic             wrap,
    output logic             ld_err
);

    // One extra bit so NUM_DAYS itself is representable for the range compare.
    localparam logic [IDX_W:0]   NUM_DAYS_W = (IDX_W+1)'(NUM_DAYS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DAYS - 1);
    localparam logic [IDX_W-1:0] RST_IDX    = IDX_W'(RESET_IDX);
    localparam logic [OUT_W-1:0] CODE_BASE  = OUT_W'(FIRST_CODE);

    logic [IDX_W-1:0] dia_idx_q, dia_idx_d;
    logic             wrap_q, wrap_d;
    logic             ld_err_q, ld_err_d;

    // Next-state: ld beats a single-direction step; inc+dec together cancel.
    always_comb begin
        dia_idx_d = dia_idx_q;
        wrap_d    = 1'b0;
        ld_err_d  = 1'b0;
        if (ld) begin
            if ({1'b0, ld_val} < NUM_DAYS_W) begin
                dia_idx_d = ld_val;
            end else begin
                ld_err_d = 1'b1;
            end
        end else if (inc ^ dec) begin
            if ({1'b0, dia_idx_q} >= NUM_DAYS_W) begin
                dia_idx_d = '0;
            end else if (inc) begin
                if (dia_idx_q == LAST_IDX) begin
                    dia_idx_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    dia_idx_d = dia_idx_q + IDX_W'(1);
                end
            end else begin
                if (dia_idx_q == '0) begin
                    dia_idx_d = LAST_IDX;
                    wrap_d    = 1'b1;
                end else begin
                    dia_idx_d = dia_idx_q - IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dia_idx_q <= RST_IDX;
            wrap_q    <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            dia_idx_q <= dia_idx_d;
            wrap_q    <= wrap_d;
            ld_err_q  <= ld_err_d;
        end
    end

    assign dia_idx  = dia_idx_q;
    assign wrap     = wrap_q;
    assign ld_err   = ld_err_q;
    assign dia_code = EN ? (CODE_BASE + OUT_W'(dia_idx_q)) : '0;

endmodule

// File: tb/tb_reg_dia_cnt.sv
// Bench for reg_dia_cnt: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a modulo-arithmetic day model.
module tb_reg_dia_cnt;

    localparam int N     = 7;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset, EN, inc, dec, ld;
    logic [IDX_W-1:0] ld_val;
    logic [IDX_W-1:0] dia_idx;
    logic [7:0]       dia_code;
    logic             wrap, ld_err;

    int n_cmp = 0;
    int n_bad = 0;

    int m_idx   = 0;
    int m_wrap  = 0;
    int m_err   = 0;
    bit m_valid = 1'b0;

    reg_dia_cnt dut (
        .clk     (clk),
        .reset   (reset),
        .EN      (EN),
        .inc     (inc),
        .dec     (dec),
        .ld      (ld),
        .ld_val  (ld_val),
        .dia_idx (dia_idx),
        .dia_code(dia_code),
        .wrap    (wrap),
        .ld_err  (ld_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Day model: indices live on a ring of N, steps are modulo N.
    always @(posedge clk) begin
        if (reset) begin
            m_idx = 0; m_wrap = 0; m_err = 0; m_valid = 1'b1;
        end else if (ld) begin
            m_wrap = 0;
            if (int'(ld_val) < N) begin
                m_idx = int'(ld_val); m_err = 0;
            end else begin
                m_err = 1;
            end
        end else begin
            m_err = 0;
            if (inc && !dec) begin
                m_wrap = (m_idx == N - 1) ? 1 : 0;
                m_idx  = (m_idx + 1) % N;
            end else if (dec && !inc) begin
                m_wrap = (m_idx == 0) ? 1 : 0;
                m_idx  = (m_idx + N - 1) % N;
            end else begin
                m_wrap = 0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_idx",  int'(dia_idx), m_idx);
            check("model_code", int'(dia_code), EN ? ((1 + m_idx) % 256) : 0);
            check("model_wrap", int'(wrap), m_wrap);
            check("model_err",  int'(ld_err), m_err);
        end
    end

    task automatic step(input logic i, input logic d, input logic l, input logic [IDX_W-1:0] v);
        inc = i; dec = d; ld = l; ld_val = v;
        @(posedge clk);
        #1;
        inc = 1'b0; dec = 1'b0; ld = 1'b0;
    endtask

    initial begin
        reset = 1'b1; EN = 1'b1; inc = 1'b0; dec = 1'b0; ld = 1'b0; ld_val = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: reset state
        check("rst_idx",  int'(dia_idx), 0);
        check("rst_code", int'(dia_code), 8'h01);
        check("rst_wrap", int'(wrap), 0);
        check("rst_err",  int'(ld_err), 0);

        // 2: a full week of incs
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            check("inc_code", int'(dia_code), (k < 6) ? (k + 2) : 1);
            check("inc_wrap", int'(wrap), (k == 6) ? 1 : 0);
        end
        check("model_pin0", m_idx, 0);

        // 3: dec wraps backwards
        step(1'b0, 1'b1, 1'b0, '0);
        check("dec_idx",  int'(dia_idx), 6);
        check("dec_code", int'(dia_code), 8'h07);
        check("dec_wrap", int'(wrap), 1);
        step(1'b0, 1'b0, 1'b0, '0);
        check("dec_wrap_clr", int'(wrap), 0);

        // 4: rejected then accepted load
        step(1'b0, 1'b0, 1'b1, 3'd7);
        check("ldbad_idx", int'(dia_idx), 6);
        check("ldbad_err", int'(ld_err), 1);
        step(1'b0, 1'b0, 1'b1, 3'd4);
        check("ld_idx",  int'(dia_idx), 4);
        check("ld_code", int'(dia_code), 8'h05);
        check("ld_err",  int'(ld_err), 0);
        check("model_pin4", m_idx, 4);

        // 5: ld beats inc; inc+dec holds
        step(1'b1, 1'b0, 1'b1, 3'd2);
        check("ldinc_idx", int'(dia_idx), 2);
        step(1'b1, 1'b1, 1'b0, '0);
        check("incdec_idx",  int'(dia_idx), 2);
        check("incdec_wrap", int'(wrap), 0);

        // 6: EN gating, then reset beats inc
        EN = 1'b0;
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("en0_code", int'(dia_code), 0);
        check("en0_idx",  int'(dia_idx), 4);
        EN = 1'b1;
        #1;
        check("en1_code", int'(dia_code), 8'h05);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        check("pre_rst_wrap", int'(wrap), 1);
        reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, '0);
        reset = 1'b0;
        check("rstinc_idx",  int'(dia_idx), 0);
        check("rstinc_wrap", int'(wrap), 0);

        // Randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            reset  = ($urandom_range(0, 59) == 0);
            EN     = ($urandom_range(0, 3) != 0);
            inc    = $urandom_range(0, 1) != 0;
            dec    = $urandom_range(0, 2) == 0;
            ld     = ($urandom_range(0, 6) == 0);
            ld_val = IDX_W'($urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        reset = 1'b0; inc = 1'b0; dec = 1'b0; ld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
